// File: rtl/game_sequencer.sv
// game_sequencer: per-frame controller for a two-tank game.
// Each tick runs one frame: the two tank moves in priority order, then both
// projectiles, then a full 256-cell scan of the storage RAM, one beat per cell.
module game_sequencer #(
    parameter int OP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       p1_move_req,
    input  logic       p2_move_req,
    input  logic [1:0] p1_dir,
    input  logic [1:0] p2_dir,
    input  logic       p1_fire,
    input  logic       p2_fire,
    input  logic [7:0] updated_pos,
    input  logic [7:0] ram_out,
    input  logic       scan_ready,
    output logic [3:0] mode,
    output logic [7:0] data,
    output logic [7:0] address,
    output logic       load_out,
    output logic       scan_valid,
    output logic [7:0] scan_addr,
    output logic [7:0] scan_cell,
    output logic       busy,
    output logic       frame_done,
    output logic       tick_overrun
);
    localparam int CW = $clog2(OP_CYCLES);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FIRST_MOVE  = 3'd1,
        SECOND_MOVE = 3'd2,
        PROJ1       = 3'd3,
        PROJ2       = 3'd4,
        SCAN_RD     = 3'd5,
        SCAN_OUT    = 3'd6,
        DONE        = 3'd7
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] op_cnt_reg;
    logic [7:0]    scan_cnt_reg;
    logic [7:0]    scan_addr_reg;
    logic [7:0]    scan_cell_reg;
    logic          prio_reg;
    logic          tick_overrun_reg;

    // Per-tank views; index 0 is tank 1, index 1 is tank 2
    logic [1:0]      move_req_vec;
    logic [1:0]      fire_vec;
    logic [1:0][1:0] dir_in_vec;
    logic [1:0]      pend_vec;
    logic [1:0][1:0] pend_dir_vec;
    logic [1:0]      proj_active_vec;
    logic [1:0][1:0] proj_dir_vec;
    logic [1:0]      issue_move_vec;
    logic [1:0]      proj_load_vec;

    logic op_last;
    logic move_tank;
    logic move_active;
    logic proj_tank;
    logic proj_act;
    logic op_busy;

    assign move_req_vec = {p2_move_req, p1_move_req};
    assign fire_vec     = {p2_fire, p1_fire};
    assign dir_in_vec   = {p2_dir, p1_dir};

    assign op_last     = (op_cnt_reg == CW'(OP_CYCLES - 1));
    // prio=0 gives tank 1 the first move slot; the second slot takes the other tank
    assign move_tank   = (state_reg == SECOND_MOVE) ^ prio_reg;
    assign move_active = ((state_reg == FIRST_MOVE) || (state_reg == SECOND_MOVE)) && pend_vec[move_tank];
    assign proj_tank   = (state_reg == PROJ2);
    assign proj_act    = ((state_reg == PROJ1) || (state_reg == PROJ2)) && proj_active_vec[proj_tank];
    // Any state currently holding a storage operation for OP_CYCLES cycles
    assign op_busy     = move_active || proj_act || (state_reg == SCAN_RD);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_tank
            logic       pend_reg;
            logic [1:0] pend_dir_reg;
            logic [1:0] last_dir_reg;
            logic       proj_active_reg;
            logic [1:0] proj_dir_reg;
            logic       chk_reg;
            logic       at_edge;

            assign issue_move_vec[gi]  = move_active && op_last && (move_tank == 1'(gi));
            assign proj_load_vec[gi]   = proj_act && op_last && (proj_tank == 1'(gi));
            assign pend_vec[gi]        = pend_reg;
            assign pend_dir_vec[gi]    = pend_dir_reg;
            assign proj_active_vec[gi] = proj_active_reg;
            assign proj_dir_vec[gi]    = proj_dir_reg;

            // Projectile has reached the playfield border in its direction of travel
            always_comb begin
                case (proj_dir_reg)
                    2'd0:    at_edge = (updated_pos[3:0] == 4'h0);
                    2'd1:    at_edge = (updated_pos[3:0] == 4'hF);
                    2'd2:    at_edge = (updated_pos[7:4] == 4'h0);
                    default: at_edge = (updated_pos[7:4] == 4'hF);
                endcase
            end

            // Pending move, last direction and projectile state for this tank
            always_ff @(posedge clk) begin
                if (!reset) begin
                    pend_reg        <= 1'b0;
                    pend_dir_reg    <= 2'd0;
                    last_dir_reg    <= (gi == 0) ? 2'd1 : 2'd0;
                    proj_active_reg <= 1'b0;
                    proj_dir_reg    <= 2'd0;
                    chk_reg         <= 1'b0;
                end else begin
                    // A fresh request beats the clear from an issue in the same cycle
                    if (move_req_vec[gi]) begin
                        pend_reg     <= 1'b1;
                        pend_dir_reg <= dir_in_vec[gi];
                    end else if (issue_move_vec[gi]) begin
                        pend_reg <= 1'b0;
                    end
                    if (issue_move_vec[gi]) begin
                        last_dir_reg <= pend_dir_reg;
                    end
                    // Storage reports the new projectile position the cycle after its load
                    chk_reg <= proj_load_vec[gi];
                    if (fire_vec[gi] && !proj_active_reg) begin
                        proj_active_reg <= 1'b1;
                        proj_dir_reg    <= last_dir_reg;
                    end else if (chk_reg && at_edge) begin
                        proj_active_reg <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // State register and operation hold counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            op_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            op_cnt_reg <= (op_busy && !op_last) ? op_cnt_reg + CW'(1) : '0;
        end
    end

    // Next-state selection; skipped slots still spend one cycle in their state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:        if (tick) state_next = FIRST_MOVE;
            FIRST_MOVE:  if (!move_active || op_last) state_next = SECOND_MOVE;
            SECOND_MOVE: if (!move_active || op_last) state_next = PROJ1;
            PROJ1:       if (!proj_act || op_last) state_next = PROJ2;
            PROJ2:       if (!proj_act || op_last) state_next = SCAN_RD;
            SCAN_RD:     if (op_last) state_next = SCAN_OUT;
            SCAN_OUT:    if (scan_ready) state_next = (scan_cnt_reg == 8'hFF) ? DONE : SCAN_RD;
            default:     state_next = IDLE;
        endcase
    end

    // Storage command and status outputs decoded from the current state
    always_comb begin
        mode     = 4'b0000;
        data     = 8'h00;
        address  = 8'h00;
        load_out = 1'b0;
        if (move_active) begin
            mode     = move_tank ? 4'b0101 : 4'b0001;
            data     = {6'b0, pend_dir_vec[move_tank]};
            load_out = op_last;
        end else if (proj_act) begin
            mode     = proj_tank ? 4'b0111 : 4'b0011;
            data     = {6'b0, proj_dir_vec[proj_tank]};
            load_out = op_last;
        end else if (state_reg == SCAN_RD) begin
            address  = scan_cnt_reg;
            load_out = op_last;
        end
        scan_valid = (state_reg == SCAN_OUT);
        busy       = (state_reg != IDLE);
        frame_done = (state_reg == DONE);
    end

    // Scan counter and beat capture, frame priority and overrun flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt_reg     <= 8'h00;
            scan_addr_reg    <= 8'h00;
            scan_cell_reg    <= 8'h00;
            prio_reg         <= 1'b0;
            tick_overrun_reg <= 1'b0;
        end else begin
            if ((state_reg == SCAN_RD) && op_last) begin
                scan_addr_reg <= scan_cnt_reg;
                scan_cell_reg <= ram_out;
            end
            // 8-bit counter wraps to 0 after the last cell, ready for the next frame
            if ((state_reg == SCAN_OUT) && scan_ready) begin
                scan_cnt_reg <= scan_cnt_reg + 8'd1;
            end
            if (state_reg == DONE) begin
                prio_reg <= ~prio_reg;
            end
            if (tick && (state_reg != IDLE)) begin
                tick_overrun_reg <= 1'b1;
            end
        end
    end

    assign scan_addr    = scan_addr_reg;
    assign scan_cell    = scan_cell_reg;
    assign tick_overrun = tick_overrun_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed frames with scoreboard queues for storage ops
// and scan beats; a monitor process compares whatever the DUT presents.
module tb_game_sequencer;
    localparam int OP_CYCLES = 2;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       p1_move_req, p2_move_req;
    logic [1:0] p1_dir, p2_dir;
    logic       p1_fire, p2_fire;
    logic [7:0] updated_pos;
    logic [7:0] ram_out;
    logic       scan_ready;
    logic [3:0] mode;
    logic [7:0] data, address, scan_addr, scan_cell;
    logic       load_out, scan_valid, busy, frame_done, tick_overrun;

    int n_vec = 0;
    int n_fail = 0;
    int cnt40 = 0;
    int fd_count = 0;
    logic stall_arm = 1'b0;

    logic [11:0] op_q [$];
    logic [15:0] scan_q [$];

    logic [3:0]  prev_mode = 4'd0;
    logic [7:0]  prev_data = 8'd0;
    int          run_len = 0;
    logic        prev_acc_ff = 1'b0;
    logic [11:0] e_op;
    logic [15:0] e_sc;

    // RAM model: cell content is a fixed function of its address
    assign ram_out = address ^ 8'h5A;

    game_sequencer #(.OP_CYCLES(OP_CYCLES)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .p1_move_req(p1_move_req), .p2_move_req(p2_move_req),
        .p1_dir(p1_dir), .p2_dir(p2_dir),
        .p1_fire(p1_fire), .p2_fire(p2_fire),
        .updated_pos(updated_pos), .ram_out(ram_out), .scan_ready(scan_ready),
        .mode(mode), .data(data), .address(address), .load_out(load_out),
        .scan_valid(scan_valid), .scan_addr(scan_addr), .scan_cell(scan_cell),
        .busy(busy), .frame_done(frame_done), .tick_overrun(tick_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic m1, input logic [1:0] d1, input logic m2,
                         input logic [1:0] d2, input logic f1, input logic f2);
        p1_move_req = m1; p1_dir = d1; p2_move_req = m2; p2_dir = d2;
        p1_fire = f1; p2_fire = f2;
        step();
        p1_move_req = 1'b0; p2_move_req = 1'b0; p1_fire = 1'b0; p2_fire = 1'b0;
    endtask

    task automatic start_frame();
        for (int a = 0; a < 256; a++) begin
            scan_q.push_back({8'(a), 8'(a) ^ 8'h5A});
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
        step();
        $display("frame %s complete, op_q=%0d", name, op_q.size());
    endtask

    task automatic wait_scan(input logic [7:0] a);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (scan_valid && scan_addr == a) seen = 1'b1;
        end
        chk("wait_scan_addr", 32'(seen), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_mode"}, 32'(mode), 32'd0);
        chk({tag, "_data"}, 32'(data), 32'd0);
        chk({tag, "_address"}, 32'(address), 32'd0);
        chk({tag, "_scan_addr"}, 32'(scan_addr), 32'd0);
        chk({tag, "_scan_cell"}, 32'(scan_cell), 32'd0);
        chk({tag, "_load_out"}, 32'(load_out), 32'd0);
        chk({tag, "_scan_valid"}, 32'(scan_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_tick_overrun"}, 32'(tick_overrun), 32'd0);
    endtask

    // Downstream: always ready, except one 5-cycle stall on the 0x40 beat when armed
    initial begin : ready_drv
        scan_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_arm && scan_valid && scan_addr == 8'h40) begin
                scan_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                scan_ready = 1'b1;
                stall_arm = 1'b0;
            end
        end
    end

    // Monitor: pops expected storage ops on load_out and expected scan beats while valid
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mode != 4'd0)
                run_len = (mode == prev_mode && data == prev_data) ? run_len + 1 : 1;
            else
                run_len = 0;
            if (load_out && mode != 4'd0) begin
                chk("op_expected", 32'(op_q.size() != 0), 32'd1);
                if (op_q.size() != 0) begin
                    e_op = op_q.pop_front();
                    $display("op mode=%b data=%02h hold=%0d exp=%03h", mode, data, run_len, e_op);
                    chk("op_mode_data", 32'({mode, data}), 32'(e_op));
                    chk("op_hold", run_len, OP_CYCLES);
                end
            end
            prev_mode = mode;
            prev_data = data;
            if (scan_valid) begin
                if (scan_addr == 8'h40) cnt40++;
                chk("beat_expected", 32'(scan_q.size() != 0), 32'd1);
                if (scan_q.size() != 0) begin
                    e_sc = scan_q[0];
                    chk("beat_addr", 32'(scan_addr), 32'(e_sc[15:8]));
                    chk("beat_cell", 32'(scan_cell), 32'(e_sc[7:0]));
                    if (scan_ready) void'(scan_q.pop_front());
                end
            end
            if (frame_done) begin
                fd_count++;
                chk("fd_after_last_beat", 32'(prev_acc_ff), 32'd1);
                chk("fd_scan_drained", scan_q.size(), 0);
            end
            prev_acc_ff = scan_valid && scan_ready && (scan_addr == 8'hFF);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        reset = 1'b0; tick = 1'b0;
        p1_move_req = 1'b0; p2_move_req = 1'b0; p1_dir = 2'd0; p2_dir = 2'd0;
        p1_fire = 1'b0; p2_fire = 1'b0; updated_pos = 8'h00;
        repeat (3) step();
        check_idle_outputs("reset");
        reset = 1'b1;
        step();

        // Frame A, prio 0: tank1 right first, tank2 up, tank1 projectile down (reset last_dir)
        pulse(1'b1, 2'd3, 1'b1, 2'd0, 1'b1, 1'b0);
        op_q.push_back(12'h1_03);
        op_q.push_back(12'h5_00);
        op_q.push_back(12'h3_01);
        start_frame();
        wait_frame("A");
        chk("A_ops_drained", op_q.size(), 0);

        // Frame B, prio 1: tank2 first; projectile survives A (row 0) and hits row 15 here
        updated_pos = 8'hFF;
        pulse(1'b1, 2'd2, 1'b1, 2'd1, 1'b0, 1'b0);
        op_q.push_back(12'h5_01);
        op_q.push_back(12'h1_02);
        op_q.push_back(12'h3_01);
        start_frame();
        wait_frame("B");
        chk("B_ops_drained", op_q.size(), 0);

        // Frame C: no ops, stall at 0x40, requests during scan, tick during SCAN_OUT
        stall_arm = 1'b1;
        cnt40 = 0;
        start_frame();
        wait_scan(8'h20);
        pulse(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        op_q.push_back(12'h1_00);
        op_q.push_back(12'h7_01);
        wait_scan(8'h80);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("C_overrun_set", 32'(tick_overrun), 32'd1);
        wait_frame("C");
        chk("C_ops_deferred", op_q.size(), 2);
        chk("C_stall_beat_cycles", cnt40, 6);
        chk("C_overrun_sticky", 32'(tick_overrun), 32'd1);
        chk("C_idle_after_frame", 32'(busy), 32'd0);

        // Frame D, prio 1: ops issue, then reset during SCAN_RD of cell 0x10
        start_frame();
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 3000 && !seen; k++) begin
                @(negedge clk);
                if (busy && address == 8'h10 && !load_out) seen = 1'b1;
            end
            chk("D_reach_scan_0x10", 32'(seen), 32'd1);
        end
        chk("D_ops_drained", op_q.size(), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_idle_outputs("abort");
        scan_q.delete();
        for (int k = 0; k < 8; k++) begin
            step();
            chk("abort_no_load", 32'(load_out), 32'd0);
        end

        // Frame F after reset: prio back to 0, tank2 last_dir back to up
        updated_pos = 8'h00;
        pulse(1'b1, 2'd1, 1'b1, 2'd2, 1'b0, 1'b1);
        op_q.push_back(12'h1_01);
        op_q.push_back(12'h5_02);
        op_q.push_back(12'h7_00);
        start_frame();
        wait_frame("F");
        chk("F_ops_drained", op_q.size(), 0);
        chk("frame_done_count", fd_count, 4);
        chk("F_overrun_clear", 32'(tick_overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
